// File: rtl/mole_pkg.sv
// mole_pkg: shared definitions for the whack-a-mole round sequencer.
//   state_t       - round state encoding driven onto the 3-bit state output
//   NUM_HOLES     - number of mole holes on the board
//   NO_HIT        - keyboard code meaning "no key pressed this cycle"
//   LFSR_TAPS     - feedback mask for the 16-bit Fibonacci LFSR
//                   (taps 16,14,13,11 expressed on a right-shifting register)
//   popcount9     - number of moles currently up in a map
package mole_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_DONE = 3'd2
  } state_t;

  localparam int          NUM_HOLES = 9;
  localparam logic [3:0]  NO_HIT    = 4'hF;
  // Bits 0,2,3,5 of a right-shifting register correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [3:0] popcount9(input logic [NUM_HOLES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit Fibonacci LFSR used as the spawn randomiser.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset, loads SEED
//   value out  current LFSR contents (advances every clock)
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else begin
      // Shift right; XOR of the tapped bits re-enters at the top.
      lfsr_reg <= {^(lfsr_reg & LFSR_TAPS), lfsr_reg[15:1]};
    end
  end

  assign value = lfsr_reg;

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole round sequencer. Owns the 9-hole mole map,
// spawns moles pseudo-randomly, ages/expires them, clears them on hits,
// keeps the score and ends the round on a tick-based timer.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   start    in   one-cycle start pulse (IDLE/DONE -> RUN)
//   hit_pos  in   one-cycle hole index 0..8, 4'hF = no hit, 9..14 ignored
//   map      out  bit i = mole up in hole i
//   score    out  scoring hits this round, saturating at 15
//   state    out  IDLE=0, RUN=1, DONE=2
//   en_music out  high while in RUN
//   hit_ok   out  one-cycle pulse on a scoring hit
//   miss     out  one-cycle pulse when at least one mole expires
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int          TICK_CYCLES = 10_000_000,
  parameter int          MOLE_LIFE   = 10,
  parameter int          SPAWN_GAP   = 5,
  parameter int          MAX_ACTIVE  = 3,
  parameter int          ROUND_TICKS = 300,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           hit_pos,
  output logic [NUM_HOLES-1:0] map,
  output logic [3:0]           score,
  output logic [2:0]           state,
  output logic                 en_music,
  output logic                 hit_ok,
  output logic                 miss
);

  localparam int LIFE_W  = $clog2(MOLE_LIFE + 1);
  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int ROUND_W = $clog2(ROUND_TICKS + 1);
  localparam int GAP_W   = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  state_t               state_reg, state_next;
  logic [PRESC_W-1:0]   presc_reg;
  logic [ROUND_W-1:0]   round_reg;
  logic [GAP_W-1:0]     gap_reg;
  logic [NUM_HOLES-1:0] map_reg;
  logic [3:0]           score_reg;
  logic                 hit_ok_reg, miss_reg, en_music_reg;

  logic [15:0]          lfsr_value;
  logic                 in_run, enter_run, tick, last_tick;
  logic                 room, spawn_now, found;
  logic [NUM_HOLES-1:0] hit_vec, expire_vec, occupied, free_vec, spawn_vec;
  logic [3:0]           cand, probe_idx;
  logic [4:0]           probe_sum;

  mole_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  assign in_run    = (state_reg == ST_RUN);
  assign enter_run = start && !in_run;
  assign tick      = in_run && (presc_reg == PRESC_W'(TICK_CYCLES - 1));
  assign last_tick = tick && (round_reg == ROUND_W'(ROUND_TICKS - 1));

  // Per-hole hit detection, expiry and life counter.
  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_hole
    logic [LIFE_W-1:0] life_reg;

    // Indices 9..15 never match a hole, so invalid codes fall out naturally.
    assign hit_vec[gi]    = in_run && (hit_pos == 4'(gi)) && map_reg[gi];
    // A same-cycle hit takes priority over expiry of the same hole.
    assign expire_vec[gi] = tick && map_reg[gi] && (life_reg == LIFE_W'(1)) && !hit_vec[gi];

    always_ff @(posedge clk) begin
      if (rst || enter_run) begin
        life_reg <= '0;
      end else if (spawn_vec[gi]) begin
        life_reg <= LIFE_W'(MOLE_LIFE);
      end else if (hit_vec[gi] || expire_vec[gi]) begin
        life_reg <= '0;
      end else if (tick && map_reg[gi]) begin
        life_reg <= life_reg - 1'b1;
      end
    end
  end

  // The hit hole still counts toward occupancy and may not be re-chosen;
  // holes expiring this tick are already free.
  assign occupied  = map_reg & ~expire_vec;
  assign free_vec  = ~occupied & ~hit_vec;
  assign room      = popcount9(occupied) < 4'(MAX_ACTIVE);
  assign spawn_now = tick && !last_tick && (gap_reg == '0) && room;

  // Linear probe from lfsr[3:0] mod 9 to the first free hole.
  always_comb begin
    spawn_vec = '0;
    found     = 1'b0;
    probe_sum = '0;
    probe_idx = '0;
    cand      = (lfsr_value[3:0] >= 4'd9) ? (lfsr_value[3:0] - 4'd9) : lfsr_value[3:0];
    for (int k = 0; k < NUM_HOLES; k++) begin
      probe_sum = {1'b0, cand} + 5'(k);
      probe_idx = (probe_sum >= 5'(NUM_HOLES)) ? 4'(probe_sum - 5'(NUM_HOLES)) : probe_sum[3:0];
      if (spawn_now && !found && free_vec[probe_idx]) begin
        spawn_vec[probe_idx] = 1'b1;
        found                = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (last_tick) state_next = ST_DONE;
      ST_DONE: if (start)     state_next = ST_RUN;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      en_music_reg <= 1'b0;
      hit_ok_reg   <= 1'b0;
      miss_reg     <= 1'b0;
      map_reg      <= '0;
      score_reg    <= '0;
      presc_reg    <= '0;
      round_reg    <= '0;
      gap_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      en_music_reg <= (state_next == ST_RUN);
      hit_ok_reg   <= |hit_vec;
      // Moles wiped by the end of the round do not count as misses.
      miss_reg     <= (|expire_vec) && !last_tick;
      if (enter_run) begin
        map_reg   <= '0;
        score_reg <= '0;
        presc_reg <= '0;
        round_reg <= '0;
        gap_reg   <= '0;
      end else if (in_run) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        if ((|hit_vec) && (score_reg != 4'hF)) begin
          score_reg <= score_reg + 1'b1;
        end
        if (last_tick) begin
          map_reg <= '0;
        end else begin
          map_reg <= (map_reg & ~hit_vec & ~expire_vec) | spawn_vec;
        end
        if (tick) begin
          round_reg <= round_reg + 1'b1;
          if (gap_reg == '0) begin
            // When full, gap stays 0 so the spawn is retried next tick.
            if (room) gap_reg <= GAP_W'(SPAWN_GAP - 1);
          end else begin
            gap_reg <= gap_reg - 1'b1;
          end
        end
      end
    end
  end

  assign map      = map_reg;
  assign score    = score_reg;
  assign state    = state_reg;
  assign en_music = en_music_reg;
  assign hit_ok   = hit_ok_reg;
  assign miss     = miss_reg;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed bench for mole_scheduler. Two instances share
// clk/rst: dut0 uses the short 20-tick round, dut_sat a 40-tick round long
// enough to score 16+ hits. A small cycle model tracks each instance so hit
// targets and spawn positions are known without reading the DUT back.
module tb_mole_scheduler;

  localparam int          TICKS = 4;
  localparam int          LIFE  = 3;
  localparam int          GAP   = 2;
  localparam int          MAXA  = 2;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [3:0] hit0, hit1;
  logic [8:0] map0, map1;
  logic [3:0] score0, score1;
  logic [2:0] state0, state1;
  logic       en0, en1, hit_ok0, hit_ok1, miss0, miss1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mole_scheduler #(.TICK_CYCLES(TICKS), .MOLE_LIFE(LIFE), .SPAWN_GAP(GAP),
                   .MAX_ACTIVE(MAXA), .ROUND_TICKS(20), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start0), .hit_pos(hit0), .map(map0),
    .score(score0), .state(state0), .en_music(en0), .hit_ok(hit_ok0), .miss(miss0));

  mole_scheduler #(.TICK_CYCLES(TICKS), .MOLE_LIFE(LIFE), .SPAWN_GAP(GAP),
                   .MAX_ACTIVE(MAXA), .ROUND_TICKS(40), .SEED(SEED)) dut_sat (
    .clk(clk), .rst(rst), .start(start1), .hit_pos(hit1), .map(map1),
    .score(score1), .state(state1), .en_music(en1), .hit_ok(hit_ok1), .miss(miss1));

  // ---------------- reference model ----------------
  int         m_state[2], m_presc[2], m_round[2], m_gap[2], m_score[2];
  int         m_life[2][9];
  logic [8:0] m_map[2];
  logic       m_en[2], m_hit_ok[2], m_miss[2];
  logic [15:0] m_lfsr;
  int         probe_hole[2];
  int         probe_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [8:0] v);
    int n = 0;
    for (int i = 0; i < 9; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int lowest(input logic [8:0] v, input logic want);
    for (int i = 0; i < 9; i++) if (v[i] == want) return i;
    return -1;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  task automatic model_reset(input int d);
    m_state[d] = 0; m_presc[d] = 0; m_round[d] = 0; m_gap[d] = 0; m_score[d] = 0;
    m_map[d] = '0; m_en[d] = 1'b0; m_hit_ok[d] = 1'b0; m_miss[d] = 1'b0;
    for (int i = 0; i < 9; i++) m_life[d][i] = 0;
  endtask

  task automatic model_step(input int d, input logic r, input logic s, input logic [3:0] h);
    logic [8:0] nm, hitbit;
    int rt, hh, c, j, cnt;
    logic tk;
    rt = (d == 0) ? 20 : 40;
    probe_hole[d] = -1;
    if (r) begin
      model_reset(d);
    end else if (m_state[d] != 1) begin
      m_hit_ok[d] = 1'b0;
      m_miss[d]   = 1'b0;
      if (s) begin
        model_reset(d);
        m_state[d] = 1;
        m_en[d]    = 1'b1;
      end
    end else begin
      tk = (m_presc[d] == TICKS - 1);
      m_presc[d] = tk ? 0 : m_presc[d] + 1;
      nm = m_map[d];
      hitbit = '0;
      hh = -1;
      m_hit_ok[d] = 1'b0;
      m_miss[d]   = 1'b0;
      if (h <= 4'd8 && m_map[d][h]) begin
        hh = int'(h);
        nm[hh] = 1'b0;
        hitbit[hh] = 1'b1;
        m_life[d][hh] = 0;
        m_hit_ok[d] = 1'b1;
        if (m_score[d] < 15) m_score[d]++;
      end
      if (tk) begin
        for (int i = 0; i < 9; i++) begin
          if (m_map[d][i] && i != hh) begin
            if (m_life[d][i] == 1) begin
              nm[i] = 1'b0;
              m_life[d][i] = 0;
              m_miss[d] = 1'b1;
            end else begin
              m_life[d][i]--;
            end
          end
        end
        m_round[d]++;
        if (m_round[d] == rt) begin
          m_state[d] = 2;
          m_en[d]    = 1'b0;
          m_miss[d]  = 1'b0;
          nm = '0;
        end else if (m_gap[d] == 0) begin
          cnt = popc(nm | hitbit);
          if (cnt < MAXA) begin
            c = int'(m_lfsr[3:0]) % 9;
            j = c;
            for (int k = 0; k < 9; k++) begin
              j = (c + k) % 9;
              if (!nm[j] && !hitbit[j]) break;
            end
            if (j != c) probe_hole[d] = j;
            nm[j] = 1'b1;
            m_life[d][j] = LIFE;
            m_gap[d] = GAP - 1;
          end
        end else begin
          m_gap[d]--;
        end
      end
      m_map[d] = nm;
    end
  endtask

  // One clock: DUT and model both consume the inputs held across the edge,
  // then every output of both instances is compared on the falling edge.
  task automatic cycle();
    logic [18:0] exp0, exp1;
    @(posedge clk);
    model_step(0, rst, start0, hit0);
    model_step(1, rst, start1, hit1);
    m_lfsr = rst ? SEED : lfsr_adv(m_lfsr);
    @(negedge clk);
    exp0 = {m_map[0], 4'(m_score[0]), 3'(m_state[0]), m_en[0], m_hit_ok[0], m_miss[0]};
    exp1 = {m_map[1], 4'(m_score[1]), 3'(m_state[1]), m_en[1], m_hit_ok[1], m_miss[1]};
    check("cyc0", {map0, score0, state0, en0, hit_ok0, miss0}, exp0);
    check("cyc1", {map1, score1, state1, en1, hit_ok1, miss1}, exp1);
    check("maxact0", 32'(popc(map0) > MAXA), 0);
    check("maxact1", 32'(popc(map1) > MAXA), 0);
    for (int d = 0; d < 2; d++) begin
      if (probe_hole[d] >= 0) begin
        probe_cnt++;
        check("probe", (d == 0) ? map0[probe_hole[d]] : map1[probe_hole[d]], 1);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state0, 0);
    check({tag, "_map"}, map0, 0);
    check({tag, "_score"}, score0, 0);
    check({tag, "_music"}, en0, 0);
    check({tag, "_hit_ok"}, hit_ok0, 0);
    check({tag, "_miss"}, miss0, 0);
  endtask

  task automatic wait_done0();
    int n = 0;
    while (state0 != 3'd2 && n < 200) begin
      cycle();
      n++;
    end
    check("done_reached", state0, 2);
  endtask

  initial begin
    logic [8:0] saved_map;
    int h, n;
    logic hitexp_seen;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; hit0 = 4'hF; hit1 = 4'hF;
    m_lfsr = SEED;
    model_reset(0);
    model_reset(1);
    repeat (3) cycle();
    check_reset_values("rst");
    rst = 1'b0;
    cycle();

    // start -> RUN next cycle, first spawn one cycle after the first tick
    start0 = 1'b1; cycle(); start0 = 1'b0;
    check("start_state", state0, 1);
    check("start_music", en0, 1);
    $display("start dut0 -> state=%0d en_music=%0b", state0, en0);
    repeat (4) cycle();
    check("first_spawn", popc(map0), 1);
    repeat (8) cycle();
    check("two_up_t3", popc(map0), 2);
    check("no_miss_t3", miss0, 0);
    repeat (4) cycle();
    check("miss_t4", miss0, 1);
    check("one_up_t4", popc(map0), 1);

    // scoring hit, empty-hole hit, invalid index
    h = lowest(m_map[0], 1'b1);
    hit0 = 4'(h); cycle(); hit0 = 4'hF;
    $display("hit dut0 hole %0d -> hit_ok=%0b score=%0d", h, hit_ok0, score0);
    check("hit_ok", hit_ok0, 1);
    check("hit_score", score0, 1);
    check("hit_clear", map0[h], 0);
    saved_map = m_map[0];
    h = lowest(m_map[0], 1'b0);
    hit0 = 4'(h); cycle(); hit0 = 4'hF;
    $display("hit dut0 empty hole %0d -> hit_ok=%0b score=%0d", h, hit_ok0, score0);
    check("empty_hit_ok", hit_ok0, 0);
    check("empty_score", score0, 1);
    check("empty_map", map0, saved_map);
    hit0 = 4'hB; cycle(); hit0 = 4'hF;
    $display("hit dut0 index 0xB -> hit_ok=%0b score=%0d", hit_ok0, score0);
    check("inval_hit_ok", hit_ok0, 0);
    check("inval_score", score0, 1);
    check("inval_map", map0, saved_map);

    // hit lands on the tick where that mole would expire
    hitexp_seen = 1'b0;
    n = 0;
    while (!hitexp_seen && n < 60) begin
      h = -1;
      if (m_state[0] == 1 && m_presc[0] == TICKS - 1)
        for (int i = 0; i < 9; i++)
          if (h < 0 && m_map[0][i] && m_life[0][i] == 1) h = i;
      if (h >= 0) begin
        hit0 = 4'(h); cycle(); hit0 = 4'hF;
        $display("hit dut0 expiring hole %0d -> hit_ok=%0b miss=%0b", h, hit_ok0, miss0);
        check("hitexp_ok", hit_ok0, 1);
        check("hitexp_miss", miss0, 0);
        hitexp_seen = 1'b1;
      end else begin
        cycle();
      end
      n++;
    end
    check("hitexp_found", hitexp_seen, 1);

    // end of round: DONE, map cleared, score held; restart clears score
    wait_done0();
    check("done_map", map0, 0);
    check("done_score", score0, 2);
    check("done_music", en0, 0);
    start0 = 1'b1; cycle(); start0 = 1'b0;
    check("restart_state", state0, 1);
    check("restart_score", score0, 0);

    // several unattended rounds to exercise collisions and the probe
    for (int r = 0; r < 8; r++) begin
      wait_done0();
      start0 = 1'b1; cycle(); start0 = 1'b0;
    end
    check("probe_seen", 32'(probe_cnt > 0), 1);

    // reset in the middle of a round
    repeat (30) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check_reset_values("midrst");

    // saturation on the long-round instance: hit every mole as it appears
    start1 = 1'b1; cycle(); start1 = 1'b0;
    n = 0;
    while (state1 != 3'd2 && n < 400) begin
      if (m_state[1] == 1 && m_map[1] != '0) hit1 = 4'(lowest(m_map[1], 1'b1));
      cycle();
      hit1 = 4'hF;
      n++;
    end
    $display("dut_sat round over -> state=%0d score=%0d", state1, score1);
    check("sat_state", state1, 2);
    check("sat_score", score1, 15);
    check("sat_map", map1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
